bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Parametrised, digit-serial packed-BCD adder/subtractor for DIGITS-wide operands. It processes one decimal digit per clock using a single one-digit BCD adder slice. For subtraction it returns sign plus magnitude, running a second serial pass to ten's-complement a negative result. It succeeds the single-digit combinational decimal adder and is used wherever multi-digit decimal arithmetic (counters, calculator datapath, display values) must be computed with small area.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width W = 4*DIGITS
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only when busy=0
- sub  in  1  0 = a+b, 1 = a−b; latched with start
- a  in  W  packed BCD operand, digit 0 in [3:0]; latched with start
- b  in  W  packed BCD operand; latched with start
- result  out  W  packed BCD result (magnitude for sub)
- carry  out  1  add: decimal carry out of top digit; sub: always 0
- neg  out  1  sub: 1 when a<b; add: always 0
- err  out  1  1 when any latched digit of a or b exceeds 9
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; result/flags valid from this cycle on

## Operation
- States: IDLE, ADD, FIX, DONE.
- IDLE: on start=1, latch a, b, sub; clear result, carry, neg, err. If any digit >9, go to DONE with err=1, result=0. Otherwise go to ADD with digit index i=0 and c=sub.
- ADD (DIGITS cycles): operand digit x = a_i, y = b_i (add) or 9−b_i (sub). The slice computes (x+y+c); a sum >9 is corrected by +6. The slice writes digit i of result and updates c. After i=DIGITS−1:
  - add: carry=c, go to DONE.
  - sub, c=1: result is non-negative; go to DONE.
  - sub, c=0: set neg=1, i=0, c=1, go to FIX.
- FIX (DIGITS cycles): result_i ← slice(0, 9−result_i, c), then update c. The final carry is discarded. Go to DONE.
- DONE (1 cycle): done=1, busy=0, go to IDLE. Outputs hold until the next accepted start.
- start while busy=1 is ignored with no effect. start in the DONE cycle is ignored.
- 0−0 and a=b give result 0, neg=0 (never "negative zero").
- rst_n=0 at any edge: state→IDLE. result, carry, neg, err, busy, done all become 0. Any in-flight operation is discarded.

## Timing
- Reset values: result=0, carry=0, neg=0, err=0, busy=0, done=0.
- start accepted at edge E0. busy=1 from E0 until the edge that enters DONE.
- done is high in the cycle after edge E(n):
  - add, or non-negative sub: n = DIGITS+1
  - negative sub: n = 2*DIGITS+1
  - err: n = 1
- Back-to-back: next start is accepted in the cycle after done. Minimum issue interval is DIGITS+2 cycles.
- Inputs a, b, sub are don't-care except at the accepting edge.

## Structure
- Shared package bcd_pkg holds:
  - state encoding constants (IDLE, ADD, FIX, DONE)
  - a nines_comp function (4-bit digit → 9−d)
  - an is_bcd function (digit ≤9)
- Natural sub-module: bcd_digit_slice. It is combinational, taking 4-bit x, y and c_in, and returning 4-bit s and c_out. It performs a binary add plus +6 correction when the sum >9. It is instantiated exactly once and shared by ADD and FIX.
- The top module contains the FSM, digit index counter (width clog2(DIGITS)), operand/result shift or indexed registers, and flags.

## Test plan
- DIGITS=4, add 1234+5678 → result 6912, carry 0, done at cycle 5 after start.
- Add 9999+0001 → result 0000, carry 1; add 0000+0000 → 0000, carry 0.
- Sub 5000−1234 → result 3766, neg 0, done at cycle 5; sub 0042−0042 → 0000, neg 0.
- Sub 0123−0456 → result 0333, neg 1, done at cycle 9. Sub 0000−9999 → 9999, neg 1.
- a=12A4 → err 1, result 0000, done at cycle 1. A subsequent valid add then clears err.
- start pulsed mid-ADD is ignored, and the original result is correct. rst_n low at cycle 3 of a sub → all outputs 0 next cycle. A new start after reset completes normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor:
// FSM state encoding and per-digit helper functions.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// One-digit BCD adder: binary add of two digits plus carry, then +6
// correction whenever the binary sum leaves the decimal range.
module bcd_digit_slice (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] sum_s;

    // Binary sum with decimal adjust
    always_comb begin
        sum_s = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, c_i};
        if (sum_s > 5'd9) begin
            s_o = sum_s[3:0] + 4'd6;
            c_o = 1'b1;
        end else begin
            s_o = sum_s[3:0];
            c_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add/subtract sharing one digit slice; a negative
// difference is turned into sign plus magnitude by a second ten's-complement pass.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry,
    output logic                  neg,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            sub_q, sub_d, c_q, c_d;
    logic            carry_q, carry_d, neg_q, neg_d, err_q, err_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            ops_ok_s;
    logic [3:0]      x_s, y_s, slice_s;
    logic            cin_s, slice_c_s;

    bcd_digit_slice u_slice (
        .x_i (x_s),
        .y_i (y_s),
        .c_i (cin_s),
        .s_o (slice_s),
        .c_o (slice_c_s)
    );

    // Operand digit validity, checked on the operands being latched
    always_comb begin
        ops_ok_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            ops_ok_s = ops_ok_s & is_bcd(a[4*k +: 4]) & is_bcd(b[4*k +: 4]);
        end
    end

    // Slice operand steering: ADD uses a/b digits, FIX complements the result digit
    always_comb begin
        x_s   = 4'd0;
        y_s   = 4'd0;
        cin_s = c_q;
        case (state_q)
            S_ADD: begin
                x_s = a_q[4*idx_q +: 4];
                y_s = sub_q ? nines_comp(b_q[4*idx_q +: 4]) : b_q[4*idx_q +: 4];
            end
            S_FIX: begin
                y_s = nines_comp(result_q[4*idx_q +: 4]);
            end
            default: begin
                cin_s = 1'b0;
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    c_d      = sub;
                    idx_d    = '0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    neg_d    = 1'b0;
                    if (ops_ok_s) begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_ADD;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                result_d[4*idx_q +: 4] = slice_s;
                c_d = slice_c_s;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (!sub_q) begin
                        carry_d = slice_c_s;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (slice_c_s) begin
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        // No end-around carry: a<b, result holds 10^DIGITS-(b-a)
                        neg_d   = 1'b1;
                        c_d     = 1'b1;
                        state_d = S_FIX;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FIX: begin
                result_d[4*idx_q +: 4] = slice_s;
                c_d = slice_c_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign neg    = neg_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub with DIGITS=4.
module tb_bcd_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        carry;
    logic        neg;
    logic        err;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .result (result),
        .carry  (carry),
        .neg    (neg),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation; optionally pulses start mid-ADD with other operands
    task automatic run_op(input string tag, input logic op_sub, input logic [15:0] op_a,
                          input logic [15:0] op_b, input logic [15:0] exp_res,
                          input logic exp_carry, input logic exp_neg, input logic exp_err,
                          input int exp_lat, input logic inject);
        int cyc;
        @(negedge clk);
        sub   = op_sub;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        sub   = 1'b0;
        check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, ~exp_err});
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (inject && cyc == 2) begin
                start = 1'b1;
                sub   = 1'b1;
                a     = 16'h9999;
                b     = 16'h0001;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, cyc, exp_lat);
        check_eq({tag, ".result"}, {16'd0, result}, {16'd0, exp_res});
        check_eq({tag, ".carry"}, {31'd0, carry}, {31'd0, exp_carry});
        check_eq({tag, ".neg"}, {31'd0, neg}, {31'd0, exp_neg});
        check_eq({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        check_eq({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, ".hold"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.outs", {10'd0, result, carry, neg, err, busy, done}, 32'd0);
        rst_n = 1'b1;

        run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 1'b0);
        run_op("add_0000_0000", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("add_5555_4445", 1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 1'b0);
        run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("sub_0042_0042", 1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("sub_0000_0000", 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("sub_0123_0456", 1'b1, 16'h0123, 16'h0456, 16'h0333, 1'b0, 1'b1, 1'b0, 9, 1'b0);
        run_op("sub_0000_9999", 1'b1, 16'h0000, 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0, 9, 1'b0);
        run_op("err_a_12A4", 1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        run_op("add_0500_0250", 1'b0, 16'h0500, 16'h0250, 16'h0750, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op("err_b_sub", 1'b1, 16'h0001, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        run_op("add_inject", 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 5, 1'b1);

        // Reset in the middle of a negative subtraction
        @(negedge clk);
        sub   = 1'b1;
        a     = 16'h0123;
        b     = 16'h0456;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midreset.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midreset.outs", {10'd0, result, carry, neg, err, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("midreset.no_done", {31'd0, done}, 32'd0);

        run_op("after_reset", 1'b1, 16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, 1'b0, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
